// File: rtl/boot_loader_if.sv
// Byte-stream input and memory write bus of the boot loader.
// The slave modport is the loader's view; master is the source/memory side.
interface boot_loader_if #(
   parameter int ADDR_W = 8
);
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;

   modport master (
      output rx_data,
      output rx_valid,
      input  rx_ready,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata
   );

   modport slave (
      input  rx_data,
      input  rx_valid,
      output rx_ready,
      output mem_we,
      output mem_addr,
      output mem_wdata
   );
endinterface

// File: rtl/boot_loader.sv
// Framed byte-stream image loader: SYNC, 16-bit word count, big-endian words, optional XOR checksum.
// Define BOOT_LOADER_CHECKSUM_EN to expect and verify the trailing checksum byte.
module boot_loader #(
   parameter int          ADDR_W  = 8,
   parameter int          TIMEOUT = 1000000,
   parameter logic [7:0]  SYNC    = 8'hA5
) (
   input  logic               clk,
   input  logic               rst,
   boot_loader_if.slave       bus,
   output logic               cpu_rst_n,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [1:0]         err_code,
   output logic [15:0]        words_loaded
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_COUNT,
      S_DATA,
`ifdef BOOT_LOADER_CHECKSUM_EN
      S_CHECK,
`endif
      S_DONE,
      S_ERROR
   } state_t;

`ifdef BOOT_LOADER_CHECKSUM_EN
   localparam state_t S_TAIL = S_CHECK;
`else
   localparam state_t S_TAIL = S_DONE;
`endif

   localparam int              TO_W      = $clog2(TIMEOUT) + 1;
   localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT - 1);
   localparam logic [32:0]     MAX_WORDS = 33'd1 << ADDR_W;

   state_t            state_q, state_d;
   logic [1:0]        byte_cnt_q, byte_cnt_d;
   logic [15:0]       count_q, count_d;
   logic [23:0]       asm_q, asm_d;
   logic [ADDR_W-1:0] word_idx_q, word_idx_d;
   logic [TO_W-1:0]   idle_q, idle_d;
`ifdef BOOT_LOADER_CHECKSUM_EN
   logic [7:0]        csum_q, csum_d;
`endif

   logic              rx_ready_q, rx_ready_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic              cpu_rst_n_q, cpu_rst_n_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [1:0]        err_code_q, err_code_d;
   logic [15:0]       words_loaded_q, words_loaded_d;

   logic              accept;
   logic [15:0]       count_full;

   assign accept     = bus.rx_valid && rx_ready_q;
   assign count_full = {count_q[7:0], bus.rx_data};

   always_comb begin
      state_d        = state_q;
      byte_cnt_d     = byte_cnt_q;
      count_d        = count_q;
      asm_d          = asm_q;
      word_idx_d     = word_idx_q;
      idle_d         = idle_q;
`ifdef BOOT_LOADER_CHECKSUM_EN
      csum_d         = csum_q;
`endif
      mem_we_d       = 1'b0;
      mem_addr_d     = mem_addr_q;
      mem_wdata_d    = mem_wdata_q;
      err_code_d     = err_code_q;
      words_loaded_d = words_loaded_q;

      if (accept) begin
         idle_d = '0;
      end

      case (state_q)
         S_IDLE: begin
            if (accept && bus.rx_data == SYNC) begin
               state_d    = S_COUNT;
               byte_cnt_d = 2'd0;
`ifdef BOOT_LOADER_CHECKSUM_EN
               csum_d     = 8'd0;
`endif
            end
         end

         S_COUNT: begin
            if (accept) begin
               if (byte_cnt_q == 2'd0) begin
                  count_d    = {8'd0, bus.rx_data};
                  byte_cnt_d = 2'd1;
               end else begin
                  count_d    = count_full;
                  byte_cnt_d = 2'd0;
                  if ({17'd0, count_full} > MAX_WORDS) begin
                     state_d    = S_ERROR;
                     err_code_d = 2'b11;
                  end else if (count_full == 16'd0) begin
                     state_d = S_TAIL;
                  end else begin
                     state_d = S_DATA;
                  end
               end
            end
         end

         S_DATA: begin
            if (accept) begin
               asm_d      = {asm_q[15:0], bus.rx_data};
               byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef BOOT_LOADER_CHECKSUM_EN
               csum_d     = csum_q ^ bus.rx_data;
`endif
               if (byte_cnt_q == 2'd3) begin
                  mem_we_d       = 1'b1;
                  mem_addr_d     = word_idx_q;
                  mem_wdata_d    = {asm_q, bus.rx_data};
                  word_idx_d     = word_idx_q + 1'b1;
                  words_loaded_d = words_loaded_q + 16'd1;
                  if (words_loaded_q + 16'd1 == count_q) begin
                     state_d = S_TAIL;
                  end
               end
            end
         end

`ifdef BOOT_LOADER_CHECKSUM_EN
         S_CHECK: begin
            if (accept) begin
               if (bus.rx_data == csum_q) begin
                  state_d = S_DONE;
               end else begin
                  state_d    = S_ERROR;
                  err_code_d = 2'b01;
               end
            end
         end
`endif

         default: begin
            // DONE and ERROR hold until reset
         end
      endcase

      // busy_q mirrors "state_q is inside a frame", so it gates the idle timer
      if (busy_q && !accept) begin
         if (idle_q == TO_LAST) begin
            state_d    = S_ERROR;
            err_code_d = 2'b10;
         end else begin
            idle_d = idle_q + 1'b1;
         end
      end

      busy_d = (state_d == S_COUNT) || (state_d == S_DATA);
`ifdef BOOT_LOADER_CHECKSUM_EN
      busy_d = busy_d || (state_d == S_CHECK);
`endif
      rx_ready_d  = busy_d || (state_d == S_IDLE);
      done_d      = (state_d == S_DONE);
      cpu_rst_n_d = (state_d == S_DONE);
      err_d       = (state_d == S_ERROR);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         byte_cnt_q     <= 2'd0;
         count_q        <= 16'd0;
         asm_q          <= 24'd0;
         word_idx_q     <= '0;
         idle_q         <= '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
         csum_q         <= 8'd0;
`endif
         rx_ready_q     <= 1'b0;
         mem_we_q       <= 1'b0;
         mem_addr_q     <= '0;
         mem_wdata_q    <= 32'd0;
         cpu_rst_n_q    <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         err_q          <= 1'b0;
         err_code_q     <= 2'b00;
         words_loaded_q <= 16'd0;
      end else begin
         state_q        <= state_d;
         byte_cnt_q     <= byte_cnt_d;
         count_q        <= count_d;
         asm_q          <= asm_d;
         word_idx_q     <= word_idx_d;
         idle_q         <= idle_d;
`ifdef BOOT_LOADER_CHECKSUM_EN
         csum_q         <= csum_d;
`endif
         rx_ready_q     <= rx_ready_d;
         mem_we_q       <= mem_we_d;
         mem_addr_q     <= mem_addr_d;
         mem_wdata_q    <= mem_wdata_d;
         cpu_rst_n_q    <= cpu_rst_n_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         err_q          <= err_d;
         err_code_q     <= err_code_d;
         words_loaded_q <= words_loaded_d;
      end
   end

   assign bus.rx_ready  = rx_ready_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign cpu_rst_n     = cpu_rst_n_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign err           = err_q;
   assign err_code      = err_code_q;
   assign words_loaded  = words_loaded_q;

endmodule
